// File: rtl/multi_edge_detect_pkg.sv
// Shared mode encodings and edge qualification helper for multi_edge_detect.
package multi_edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  // True when the observed transition is one the channel mode asks for.
  function automatic logic qualifies(mode_t m, logic rise, logic fall);
    return (rise && (m == MODE_RISE || m == MODE_BOTH)) ||
           (fall && (m == MODE_FALL || m == MODE_BOTH));
  endfunction

endpackage

// File: rtl/multi_edge_detect_edge_chan.sv
// One edge-detect channel: optional synchronizer, history, arming, pulse, sticky and counter.
// EDGE_SYNC_EN inserts a SYNC_STAGES-deep synchronizer ahead of the sampled level.
module edge_chan
  import multi_edge_detect_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             edge_out,
  output logic             edge_pol,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

`ifdef EDGE_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  // Arming waits until the sampled level reflects real input, so a held level never looks like an edge.
  localparam int unsigned ARM_LEN = SYNC_EN ? SYNC_STAGES + 1 : 1;

  logic               s;
  logic               h;
  logic               armed;
  logic               hit;
  logic [ARM_LEN-1:0] arm_q;
  mode_t              mode_q;

`ifdef EDGE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = d;
`endif

  assign armed = arm_q[ARM_LEN-1];

  // Mode is registered so a change applies from the following sample onward.
  always_comb hit = armed && qualifies(mode_q, s & ~h, ~s & h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q    <= '0;
      h        <= 1'b0;
      mode_q   <= MODE_OFF;
      edge_out <= 1'b0;
      edge_pol <= 1'b0;
      sticky   <= 1'b0;
      cnt      <= '0;
    end else begin
      arm_q    <= ARM_LEN'({arm_q, 1'b1});
      h        <= s;
      mode_q   <= mode_t'(mode);
      edge_out <= hit;
      edge_pol <= s;
      // An edge beats a coincident clear: the channel restarts at one event.
      if (hit) begin
        sticky <= 1'b1;
        if (clr)       cnt <= CNT_W'(1);
        else if (&cnt) cnt <= cnt;
        else           cnt <= cnt + CNT_W'(1);
      end else if (clr) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector with per-channel mode, sticky flag and saturating counter.
// Define EDGE_SYNC_EN to add a SYNC_STAGES-deep input synchronizer per channel.
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       clr,
  output logic [WIDTH-1:0]       edge_out,
  output logic [WIDTH-1:0]       edge_pol,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH*CNT_W-1:0] cnt,
  output logic                   any_evt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (data_in[i]),
      .mode    (mode[2*i +: 2]),
      .clr     (clr[i]),
      .edge_out(edge_out[i]),
      .edge_pol(edge_pol[i]),
      .sticky  (sticky[i]),
      .cnt     (cnt[i*CNT_W +: CNT_W])
    );
  end

  // Combinational so the summary flag tracks sticky with no extra delay.
  assign any_evt = |sticky;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: expectations queued at stimulus time, checked at negedge.
module tb_multi_edge_detect;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SYNC_STAGES = 3;
`ifdef EDGE_SYNC_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int SAT = (1 << CNT_W) - 1;

  localparam int SEL_OUT     = 0;
  localparam int SEL_POL     = 1;
  localparam int SEL_STK     = 2;
  localparam int SEL_CNT     = 3;
  localparam int SEL_ANY     = 4;
  localparam int SEL_VEC_OUT = 5;
  localparam int SEL_VEC_POL = 6;
  localparam int SEL_CNT_ALL = 7;
  localparam int SEL_VEC_STK = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WIDTH-1:0]       data_in;
  logic [2*WIDTH-1:0]     mode;
  logic [WIDTH-1:0]       clr;
  logic [WIDTH-1:0]       edge_out;
  logic [WIDTH-1:0]       edge_pol;
  logic [WIDTH-1:0]       sticky;
  logic [WIDTH*CNT_W-1:0] cnt;
  logic                   any_evt;

  multi_edge_detect #(
    .WIDTH      (WIDTH),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .mode    (mode),
    .clr     (clr),
    .edge_out(edge_out),
    .edge_pol(edge_pol),
    .sticky  (sticky),
    .cnt     (cnt),
    .any_evt (any_evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    int          ch;
    logic [31:0] exp_val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void sb_push(int due, int sel, int ch, logic [31:0] exp_val, string name);
    exp_t e;
    int   idx;
    e.due = due; e.sel = sel; e.ch = ch; e.exp_val = exp_val; e.name = name;
    idx = sb.size();
    for (int j = 0; j < sb.size(); j++) begin
      if (sb[j].due > due) begin
        idx = j;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  function automatic logic [31:0] observe(int sel, int ch);
    case (sel)
      SEL_OUT:     return 32'(edge_out[ch]);
      SEL_POL:     return 32'(edge_pol[ch]);
      SEL_STK:     return 32'(sticky[ch]);
      SEL_CNT:     return 32'(cnt[ch*CNT_W +: CNT_W]);
      SEL_ANY:     return 32'(any_evt);
      SEL_VEC_OUT: return 32'(edge_out);
      SEL_VEC_POL: return 32'(edge_pol & edge_out);
      SEL_CNT_ALL: return 32'(cnt);
      SEL_VEC_STK: return 32'(sticky);
      default:     return 32'h0;
    endcase
  endfunction

  // Silence all channels, drop inputs, and clear every counter and flag.
  task automatic quiesce();
    @(negedge clk);
    mode = '0;
    clr  = '0;
    repeat (2) @(negedge clk);
    data_in = '0;
    repeat (LAT + 3) @(negedge clk);
    clr = '1;
    @(negedge clk);
    clr = '0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] got;
    int          c;
    rst_n   = 1'b0;
    data_in = '1;
    mode    = 16'h5555;
    clr     = '0;
    for (int k = 0; k < LAT + 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sb_push(cyc, SEL_VEC_OUT, 0, 32'h0, "reset_edge_out");
        sb_push(cyc, SEL_VEC_STK, 0, 32'h0, "reset_sticky");
        sb_push(cyc, SEL_CNT_ALL, 0, 32'h0, "reset_cnt");
        sb_push(cyc, SEL_ANY, 0, 32'h0, "reset_any_evt");
      end
      if (k == 3) begin
        rst_n = 1'b1;
        c = cyc;
        for (int d = 1; d <= LAT + 5; d++) sb_push(c + d, SEL_VEC_OUT, 0, 32'h0, "held_high_no_pulse");
        sb_push(c + LAT + 5, SEL_CNT_ALL, 0, 32'h0, "held_high_cnt");
        sb_push(c + LAT + 5, SEL_VEC_STK, 0, 32'h0, "held_high_sticky");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_reset: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_rise();
    exp_t        e;
    logic [31:0] got;
    int          c;
    quiesce();
    mode[1:0] = 2'b01;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_in[0] = 1'b1;
        c = cyc;
        sb_push(c + LAT - 1, SEL_OUT, 0, 32'h0, "rise_before_latency");
        sb_push(c + LAT, SEL_OUT, 0, 32'h1, "rise_pulse");
        sb_push(c + LAT, SEL_POL, 0, 32'h1, "rise_pol");
        sb_push(c + LAT, SEL_CNT, 0, 32'h1, "rise_cnt");
        sb_push(c + LAT, SEL_STK, 0, 32'h1, "rise_sticky");
        sb_push(c + LAT, SEL_ANY, 0, 32'h1, "rise_any_evt");
        sb_push(c + LAT + 1, SEL_OUT, 0, 32'h0, "rise_pulse_width");
        sb_push(c + LAT + 2, SEL_CNT, 0, 32'h1, "rise_cnt_hold");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_rise: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fall();
    exp_t        e;
    logic [31:0] got;
    int          c;
    quiesce();
    mode[5:4] = 2'b10;
    for (int k = 0; k < 2 * LAT + 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_in[2] = 1'b1;
        c = cyc;
        sb_push(c + LAT, SEL_OUT, 2, 32'h0, "fall_mode_ignores_rise");
        sb_push(c + LAT + 1, SEL_STK, 2, 32'h0, "fall_mode_no_sticky");
      end
      if (k == LAT + 5) begin
        data_in[2] = 1'b0;
        c = cyc;
        sb_push(c + LAT - 1, SEL_OUT, 2, 32'h0, "fall_before_latency");
        sb_push(c + LAT, SEL_OUT, 2, 32'h1, "fall_pulse");
        sb_push(c + LAT, SEL_POL, 2, 32'h0, "fall_pol");
        sb_push(c + LAT + 1, SEL_OUT, 2, 32'h0, "fall_pulse_width");
        sb_push(c + LAT + 1, SEL_CNT, 2, 32'h1, "fall_cnt");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_fall: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_saturate();
    exp_t        e;
    logic [31:0] got;
    int          j;
    quiesce();
    mode[3:2] = 2'b11;
    for (int k = 0; k < LAT + 28; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 22) begin
        j = k - 2;
        data_in[1] = ~data_in[1];
        sb_push(cyc + LAT, SEL_OUT, 1, 32'h1, "toggle_pulse");
        sb_push(cyc + LAT, SEL_POL, 1, (j % 2 == 0) ? 32'h1 : 32'h0, "toggle_pol");
        sb_push(cyc + LAT, SEL_CNT, 1, 32'((j + 1 < SAT) ? j + 1 : SAT), "toggle_cnt");
      end
      if (k == 22) begin
        sb_push(cyc + LAT, SEL_OUT, 1, 32'h0, "toggle_stop");
        sb_push(cyc + LAT + 3, SEL_CNT, 1, 32'(SAT), "saturated_hold");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_saturate: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_clear();
    exp_t        e;
    logic [31:0] got;
    int          c;
    quiesce();
    mode[7:6] = 2'b01;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sb_push(cyc, SEL_CNT_ALL, 0, 32'h0, "clr_only_cnt");
        sb_push(cyc, SEL_ANY, 0, 32'h0, "clr_only_any_evt");
      end
      if (k == 2) begin
        data_in[3] = 1'b1;
        c = cyc;
        sb_push(c + LAT, SEL_OUT, 3, 32'h1, "clr_edge_pulse");
        sb_push(c + LAT, SEL_CNT, 3, 32'h1, "clr_edge_cnt");
        sb_push(c + LAT, SEL_STK, 3, 32'h1, "clr_edge_sticky");
        sb_push(c + LAT + 1, SEL_CNT, 3, 32'h0, "clr_after_cnt");
        sb_push(c + LAT + 1, SEL_STK, 3, 32'h0, "clr_after_sticky");
        sb_push(c + LAT + 1, SEL_ANY, 0, 32'h0, "clr_after_any_evt");
        sb_push(c + LAT + 1, SEL_OUT, 3, 32'h0, "clr_after_pulse");
      end
      if (k == 2 + LAT - 1) clr[3] = 1'b1;
      if (k == 2 + LAT + 1) clr[3] = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_clear: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mode_switch();
    exp_t        e;
    logic [31:0] got;
    quiesce();
    mode[11:10] = 2'b01;
    for (int k = 0; k < 2 * LAT + 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_in[5] = 1'b1;
        sb_push(cyc + LAT, SEL_OUT, 5, 32'h1, "switch_last_pulse");
        sb_push(cyc + LAT, SEL_CNT, 5, 32'h1, "switch_last_cnt");
      end
      if (k == 2 + LAT - 1) mode[11:10] = 2'b00;
      if (k == LAT + 5) begin
        data_in[5] = 1'b0;
        sb_push(cyc + LAT, SEL_OUT, 5, 32'h0, "switch_off_fall");
      end
      if (k == LAT + 7) begin
        data_in[5] = 1'b1;
        sb_push(cyc + LAT, SEL_OUT, 5, 32'h0, "switch_off_rise");
        sb_push(cyc + LAT + 1, SEL_CNT, 5, 32'h1, "switch_off_cnt");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_mode_switch: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] got;
    quiesce();
    mode = 16'hE4E4;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_in = '1;
        sb_push(cyc + LAT, SEL_VEC_OUT, 0, 32'hAA, "multi_rise_out");
        sb_push(cyc + LAT, SEL_VEC_POL, 0, 32'hAA, "multi_rise_pol");
      end
      if (k == 3) begin
        data_in = '0;
        sb_push(cyc + LAT, SEL_VEC_OUT, 0, 32'hCC, "multi_fall_out");
        sb_push(cyc + LAT, SEL_VEC_POL, 0, 32'h00, "multi_fall_pol");
      end
      if (k == 4) begin
        data_in = '1;
        sb_push(cyc + LAT, SEL_VEC_OUT, 0, 32'hAA, "multi_rise2_out");
        sb_push(cyc + LAT + 1, SEL_VEC_OUT, 0, 32'h00, "multi_idle_out");
        sb_push(cyc + LAT + 2, SEL_CNT_ALL, 0, 32'h31203120, "multi_cnt");
        sb_push(cyc + LAT + 2, SEL_VEC_STK, 0, 32'hEE, "multi_sticky");
        sb_push(cyc + LAT + 2, SEL_ANY, 0, 32'h1, "multi_any_evt");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_back_to_back: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t        e;
    logic [31:0] got;
    int          c;
    quiesce();
    mode[1:0] = 2'b01;
    for (int k = 0; k < 2 * LAT + 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_in[0] = 1'b1;
        sb_push(cyc + LAT, SEL_OUT, 0, 32'h1, "midrst_pulse_seen");
      end
      if (k == 2 + LAT + 2) begin
        rst_n = 1'b1;
        c = cyc;
        for (int d = 1; d <= LAT + 4; d++) sb_push(c + d, SEL_VEC_OUT, 0, 32'h0, "midrst_release_no_pulse");
        sb_push(c + LAT + 4, SEL_CNT_ALL, 0, 32'h0, "midrst_release_cnt");
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        got = observe(e.sel, e.ch);
        n_cmp++;
        if (got !== e.exp_val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: observed %0h, expected %0h", e.name, cyc, got, e.exp_val);
        end
      end
      if (k == 2 + LAT) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (edge_out !== '0) begin
          n_bad++;
          $display("FAIL midrst_edge_out: observed %0h, expected 0", edge_out);
        end
        n_cmp++;
        if (sticky !== '0) begin
          n_bad++;
          $display("FAIL midrst_sticky: observed %0h, expected 0", sticky);
        end
        n_cmp++;
        if (cnt !== '0) begin
          n_bad++;
          $display("FAIL midrst_cnt: observed %0h, expected 0", cnt);
        end
        n_cmp++;
        if (any_evt !== 1'b0) begin
          n_bad++;
          $display("FAIL midrst_any_evt: observed %0b, expected 0", any_evt);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL test_reset_mid_pulse: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_saturate();
    test_clear();
    test_mode_switch();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
